// File: rtl/dual_one_clock_fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO and its bench.
package dual_one_clock_fifo_pkg;

   // Edges between an accepted write into an empty FIFO and that word on q.
   localparam int FALL_THROUGH_LAT = 2;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dual_one_clock_fifo_if.sv
// Producer/consumer handshake plus status bundle for dual_one_clock_fifo.
interface dual_one_clock_fifo_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 512
);
   import dual_one_clock_fifo_pkg::*;

   localparam int CW = cnt_width(DEPTH);

   logic             clr;
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] d;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] q;
   logic [CW-1:0]    count;
   logic             almost_full;
   logic             overflow;
   logic [CW-1:0]    hwm;

   modport master (
      output clr, wr_valid, d, rd_ready,
      input  wr_ready, rd_valid, q, count, almost_full, overflow, hwm
   );

   modport slave (
      input  clr, wr_valid, d, rd_ready,
      output wr_ready, rd_valid, q, count, almost_full, overflow, hwm
   );

endinterface

// File: rtl/dual_one_clock_ram_bypass.sv
// WIDTH x DEPTH synchronous dual-port RAM, registered read, write-first on address collision.
module dual_one_clock_ram_bypass
   import dual_one_clock_fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 512
) (
   input  logic                        clk,
   input  logic                        we_i,
   input  logic [ptr_width(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]            wdata_i,
   input  logic                        re_i,
   input  logic [ptr_width(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]            rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: the array and its read register have no reset so they map onto block RAM;
   // the FIFO's valid flags decide when rdata_o is meaningful.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dual_one_clock_fifo.sv
// Single-clock valid/ready FIFO on a bypassing dual-port RAM with a prefetch stage and output register.
// Optional high-water mark tracking enabled by defining DUAL_ONE_CLOCK_FIFO_HWM_EN.
module dual_one_clock_fifo
   import dual_one_clock_fifo_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 512,
   parameter int AFULL_LEVEL = DEPTH - 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dual_one_clock_fifo_if.slave  bus
);

   localparam int            PW      = ptr_width(DEPTH);
   localparam int            CW      = cnt_width(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d, ram_cnt;
   logic             rd_valid_q, rd_valid_d, stage_valid_q, stage_valid_d;
   logic [WIDTH-1:0] q_q, q_d, ram_rdata;
   logic             wr_ready_q, wr_ready_d, afull_q, afull_d, ovf_q, ovf_d;
   logic             wr_acc, rd_acc, out_load, ram_re, ram_we;

   dual_one_clock_ram_bypass #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.d),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // Words live in three places: RAM, the RAM read register (stage) and q. count covers all of them.
   // NOTE: every signal gets its default before any branch so no latch can be inferred.
   always_comb begin
      wr_acc        = bus.wr_valid && wr_ready_q;
      rd_acc        = rd_valid_q && bus.rd_ready;
      ram_cnt       = count_q - CW'(rd_valid_q) - CW'(stage_valid_q);
      out_load      = stage_valid_q && (!rd_valid_q || rd_acc);
      ram_re        = !bus.clr && (ram_cnt != '0) && (!stage_valid_q || out_load);
      ram_we        = !bus.clr && wr_acc;

      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      rd_valid_d    = rd_valid_q;
      stage_valid_d = stage_valid_q;
      q_d           = q_q;
      ovf_d         = ovf_q;

      if (bus.clr) begin
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         rd_valid_d    = 1'b0;
         stage_valid_d = 1'b0;
         ovf_d         = 1'b0;
      end else begin
         if (ram_we) wr_ptr_d = wr_ptr_q + PW'(1);
         if (ram_re) rd_ptr_d = rd_ptr_q + PW'(1);

         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase

         if (out_load) begin
            rd_valid_d = 1'b1;
            q_d        = ram_rdata;
         end else if (rd_acc) begin
            rd_valid_d = 1'b0;
         end

         if (ram_re)        stage_valid_d = 1'b1;
         else if (out_load) stage_valid_d = 1'b0;

         if (bus.wr_valid && !wr_ready_q) ovf_d = 1'b1;
      end

      wr_ready_d = (count_d < DEPTH_C);
      afull_d    = (count_d >= AFULL_C);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         rd_valid_q    <= 1'b0;
         stage_valid_q <= 1'b0;
         q_q           <= '0;
         wr_ready_q    <= 1'b1;
         afull_q       <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         rd_valid_q    <= rd_valid_d;
         stage_valid_q <= stage_valid_d;
         q_q           <= q_d;
         wr_ready_q    <= wr_ready_d;
         afull_q       <= afull_d;
         ovf_q         <= ovf_d;
      end
   end

`ifdef DUAL_ONE_CLOCK_FIFO_HWM_EN
   logic [CW-1:0] hwm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_q <= '0;
      end else if (bus.clr) begin
         hwm_q <= '0;
      end else if (count_d > hwm_q) begin
         hwm_q <= count_d;
      end
   end

   assign bus.hwm = hwm_q;
`else
   assign bus.hwm = '0;
`endif

   assign bus.wr_ready    = wr_ready_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.q           = q_q;
   assign bus.count       = count_q;
   assign bus.almost_full = afull_q;
   assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_dual_one_clock_fifo.sv
// Self-checking bench for dual_one_clock_fifo: directed vector table, corner sequences, random traffic vs queue model.
module tb_dual_one_clock_fifo;
   import dual_one_clock_fifo_pkg::*;

   localparam int WIDTH       = 16;
   localparam int DEPTH       = 8;
   localparam int AFULL_LEVEL = DEPTH - 4;
`ifdef DUAL_ONE_CLOCK_FIFO_HWM_EN
   localparam bit HWM_ON = 1'b1;
`else
   localparam bit HWM_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dual_one_clock_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_if ();

   dual_one_clock_fifo #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL_LEVEL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (fifo_if)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the FIFO contents as a queue, each word tagged with its write edge.
   // The head is visible on q once FALL_THROUGH_LAT edges have passed since it was written.
   typedef struct {
      logic [WIDTH-1:0] data;
      int               cyc;
   } ent_t;

   ent_t mq[$];
   int   cyc   = 0;
   bit   m_rv  = 1'b0;
   bit   m_ovf = 1'b0;
   int   m_hwm = 0;

   task automatic model_reset();
      mq.delete();
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_hwm = 0;
   endtask

   task automatic model_edge(input bit wv, input logic [WIDTH-1:0] dd, input bit rr, input bit cl);
      bit wrdy;
      bit racc;
      wrdy = (mq.size() < DEPTH);
      racc = rr && m_rv;
      cyc++;
      if (cl) begin
         model_reset();
      end else begin
         if (wv && !wrdy) m_ovf = 1'b1;
         if (racc) void'(mq.pop_front());
         if (wv && wrdy) mq.push_back('{dd, cyc});
         if (mq.size() > m_hwm) m_hwm = mq.size();
      end
      m_rv = 1'b0;
      if (mq.size() > 0) m_rv = (mq[0].cyc <= cyc - FALL_THROUGH_LAT);
   endtask

   task automatic model_check(input string tag);
      check($sformatf("%s.rd_valid", tag), 32'(fifo_if.rd_valid), 32'(m_rv));
      if (m_rv) check($sformatf("%s.q", tag), 32'(fifo_if.q), 32'(mq[0].data));
      check($sformatf("%s.count", tag), 32'(fifo_if.count), 32'(mq.size()));
      check($sformatf("%s.wr_ready", tag), 32'(fifo_if.wr_ready), 32'(mq.size() < DEPTH));
      check($sformatf("%s.almost_full", tag), 32'(fifo_if.almost_full), 32'(mq.size() >= AFULL_LEVEL));
      check($sformatf("%s.overflow", tag), 32'(fifo_if.overflow), 32'(m_ovf));
      check($sformatf("%s.hwm", tag), 32'(fifo_if.hwm), HWM_ON ? 32'(m_hwm) : 32'd0);
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic step(input bit wv, input logic [WIDTH-1:0] dd, input bit rr, input bit cl);
      fifo_if.wr_valid = wv;
      fifo_if.d        = dd;
      fifo_if.rd_ready = rr;
      fifo_if.clr      = cl;
      @(posedge clk);
      model_edge(wv, dd, rr, cl);
      @(negedge clk);
   endtask

   typedef struct {
      bit               wv;
      logic [WIDTH-1:0] d;
      bit               rr;
      bit               cl;
      bit               rv;
      logic [WIDTH-1:0] q;
      int               cnt;
      bit               wrdy;
      bit               af;
      bit               ovf;
      int               hwm;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit wv, input logic [WIDTH-1:0] d, input bit rr, input bit cl,
                      input bit rv, input logic [WIDTH-1:0] q, input int cnt,
                      input bit wrdy, input bit af, input bit ovf, input int hwm);
      tbl.push_back('{wv, d, rr, cl, rv, q, cnt, wrdy, af, ovf, hwm});
   endtask

   initial begin
      fifo_if.wr_valid = 1'b0;
      fifo_if.d        = '0;
      fifo_if.rd_ready = 1'b0;
      fifo_if.clr      = 1'b0;

      //      wv d      rr cl | rv q   cnt wrdy af ovf hwm
      add(1, 16'h0001, 0, 0,  0, 0,  1,  1,  0, 0,  1);  // fall-through: invisible after N
      add(0, 16'h0000, 0, 0,  0, 0,  1,  1,  0, 0,  1);  // still invisible after N+1
      add(0, 16'h0000, 0, 0,  1, 1,  1,  1,  0, 0,  1);  // visible after N+2
      for (int k = 2; k <= DEPTH; k++)
         add(1, 16'(k), 0, 0, 1, 1, k, k < DEPTH, k >= AFULL_LEVEL, 0, k);
      add(1, 16'h0009, 0, 0,  1, 1,  8,  0,  1, 1,  8);  // write while full: dropped, overflow
      add(0, 16'h0000, 1, 0,  1, 2,  7,  1,  1, 1,  8);  // first read took word 1
      add(0, 16'h0000, 1, 0,  1, 3,  6,  1,  1, 1,  8);
      add(0, 16'h0000, 1, 0,  1, 4,  5,  1,  1, 1,  8);
      add(1, 16'h00AA, 1, 1,  0, 0,  0,  1,  0, 0,  0);  // clr beats both handshakes
      add(0, 16'h0000, 1, 0,  0, 0,  0,  1,  0, 0,  0);
      add(0, 16'h0000, 1, 0,  0, 0,  0,  1,  0, 0,  0);

      repeat (2) @(negedge clk);
      check("reset.count", 32'(fifo_if.count), 32'd0);
      check("reset.rd_valid", 32'(fifo_if.rd_valid), 32'd0);
      check("reset.q", 32'(fifo_if.q), 32'd0);
      check("reset.wr_ready", 32'(fifo_if.wr_ready), 32'd1);
      check("reset.almost_full", 32'(fifo_if.almost_full), 32'd0);
      check("reset.overflow", 32'(fifo_if.overflow), 32'd0);
      check("reset.hwm", 32'(fifo_if.hwm), 32'd0);
      rst_n = 1'b1;
      model_reset();

      foreach (tbl[i]) begin
         step(tbl[i].wv, tbl[i].d, tbl[i].rr, tbl[i].cl);
         check($sformatf("tbl%0d.rd_valid", i), 32'(fifo_if.rd_valid), 32'(tbl[i].rv));
         if (tbl[i].rv) check($sformatf("tbl%0d.q", i), 32'(fifo_if.q), 32'(tbl[i].q));
         check($sformatf("tbl%0d.count", i), 32'(fifo_if.count), 32'(tbl[i].cnt));
         check($sformatf("tbl%0d.wr_ready", i), 32'(fifo_if.wr_ready), 32'(tbl[i].wrdy));
         check($sformatf("tbl%0d.almost_full", i), 32'(fifo_if.almost_full), 32'(tbl[i].af));
         check($sformatf("tbl%0d.overflow", i), 32'(fifo_if.overflow), 32'(tbl[i].ovf));
         check($sformatf("tbl%0d.hwm", i), 32'(fifo_if.hwm), HWM_ON ? 32'(tbl[i].hwm) : 32'd0);
      end

      // Empty FIFO: write with rd_ready already high; nothing may be read before rd_valid rises.
      step(1, 16'h1234, 1, 0);
      model_check("empty_wr_rd0");
      for (int i = 0; i < 4; i++) begin
         step(0, '0, 1, 0);
         model_check($sformatf("empty_wr_rd%0d", i + 1));
      end
      check("empty_wr_rd.final_count", 32'(fifo_if.count), 32'd0);

      // Full-rate streaming across several pointer wraps.
      for (int i = 0; i < 3 * DEPTH + 3; i++) begin
         step(1, 16'(16'h0100 + i), 1, 0);
         model_check($sformatf("stream%0d", i));
      end
      check("stream.steady_count", 32'(fifo_if.count), 32'(FALL_THROUGH_LAT + 1));
      for (int i = 0; i < 6; i++) begin
         step(0, '0, 1, 0);
         model_check($sformatf("drain%0d", i));
      end

      // High-water mark: clear, fill to 6, drain completely.
      step(0, '0, 0, 1);
      model_check("hwm_clr");
      for (int i = 0; i < 6; i++) begin
         step(1, 16'(16'h0200 + i), 0, 0);
         model_check($sformatf("hwm_fill%0d", i));
      end
      for (int i = 0; i < 10; i++) begin
         step(0, '0, 1, 0);
         model_check($sformatf("hwm_drain%0d", i));
      end
      check("hwm_after_drain", 32'(fifo_if.hwm), HWM_ON ? 32'd6 : 32'd0);
      check("hwm_drain.count", 32'(fifo_if.count), 32'd0);

      // Random traffic with varying producer/consumer pressure and rare flushes.
      for (int i = 0; i < 800; i++) begin
         int  wbias;
         int  rbias;
         wbias = ((i / 100) % 2 == 0) ? 3 : 1;
         rbias = ((i / 100) % 2 == 0) ? 1 : 3;
         step(($urandom_range(3) < wbias), 16'($urandom), ($urandom_range(3) < rbias),
              ($urandom_range(79) == 0));
         model_check($sformatf("rand%0d", i));
      end

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 5; i++) step(1, 16'(16'h0300 + i), 0, 0);
      fifo_if.wr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst.count", 32'(fifo_if.count), 32'd0);
      check("async_rst.rd_valid", 32'(fifo_if.rd_valid), 32'd0);
      check("async_rst.q", 32'(fifo_if.q), 32'd0);
      check("async_rst.wr_ready", 32'(fifo_if.wr_ready), 32'd1);
      check("async_rst.almost_full", 32'(fifo_if.almost_full), 32'd0);
      check("async_rst.hwm", 32'(fifo_if.hwm), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(i < 2, 16'(16'h0400 + i), 1, 0);
         model_check($sformatf("post_rst%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
